cbb_rr_stream_arb: RTL and testbench

CBB_RR_STREAM_ARB -- requirements
Module: cbb_rr_stream_arb

---
 rtl/cbb_arb_pkg.sv | 34 +++
 rtl/cbb_rr_pick.sv | 47 ++++
 rtl/cbb_rr_stream_arb.sv | 145 ++++++++++++++
 tb/tb_cbb_rr_stream_arb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbb_arb_pkg.sv
// Shared types for the round-robin stream arbiter: lock FSM states and a
// reference round-robin search helper (first requester at or after a pointer).
package cbb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_SLV = 16;

  // Returns {found, index}: index of the first set bit of req at or after ptr,
  // wrapping modulo num. Widths sized for the largest supported requester count.
  function automatic logic [4:0] rr_first_idx(
    input logic [15:0] req,
    input logic [3:0]  ptr,
    input int          num
  );
    logic       found;
    logic [3:0] idx;
    logic [3:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < ARB_MAX_SLV; i++) begin
      cand = 4'((int'(ptr) + i) % num);
      if (!found && (i < num) && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/cbb_rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the offset back to an absolute index.
module cbb_rr_pick
  import cbb_arb_pkg::*;
#(
  parameter int P_NUM_SLV     = 4,
  parameter int P_GRANT_WIDTH = $clog2(P_NUM_SLV)
) (
  input  logic [P_NUM_SLV-1:0]     req,
  input  logic [P_GRANT_WIDTH-1:0] ptr,
  output logic                     found,
  output logic [P_GRANT_WIDTH-1:0] idx
);

  logic [2*P_NUM_SLV-2:0]   req_dbl;
  logic [P_NUM_SLV-1:0]     req_rot;
  logic [P_GRANT_WIDTH-1:0] off;
  logic [P_GRANT_WIDTH:0]   sum;

  assign req_dbl = {req[P_NUM_SLV-2:0], req};

  // req_rot[i] = req[(ptr + i) mod P_NUM_SLV]
  always_comb begin
    req_rot = req;
    for (int r = 1; r < P_NUM_SLV; r++) begin
      if (ptr == P_GRANT_WIDTH'(r)) begin
        req_rot = req_dbl[r +: P_NUM_SLV];
      end
    end
  end

  always_comb begin
    off = '0;
    for (int i = P_NUM_SLV - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off = P_GRANT_WIDTH'(i);
      end
    end
  end

  assign found = |req;
  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign idx   = (sum >= (P_GRANT_WIDTH+1)'(P_NUM_SLV))
               ? P_GRANT_WIDTH'(sum - (P_GRANT_WIDTH+1)'(P_NUM_SLV))
               : sum[P_GRANT_WIDTH-1:0];

endmodule

// File: rtl/cbb_rr_stream_arb.sv
// Round-robin N:1 stream arbiter with a full output register (1-cycle latency, stalls hold the
// register, drain+load in one cycle); CBB_RR_ARB_PKT_LOCK_EN keeps a grant until the last beat.
module cbb_rr_stream_arb
  import cbb_arb_pkg::*;
#(
  parameter int P_DATA_WIDTH  = 64,
  parameter int P_NUM_SLV     = 4,
  parameter int P_GRANT_WIDTH = $clog2(P_NUM_SLV)
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic [P_NUM_SLV-1:0]              slv_i_valid,
  input  logic [P_NUM_SLV*P_DATA_WIDTH-1:0] slv_i_data,
  input  logic [P_NUM_SLV-1:0]              slv_i_last,
  output logic [P_NUM_SLV-1:0]              slv_o_ready,
  output logic                              mst_o_valid,
  output logic [P_DATA_WIDTH-1:0]           mst_o_data,
  output logic                              mst_o_last,
  output logic [P_GRANT_WIDTH-1:0]          mst_o_grant,
  input  logic                              mst_i_ready
);

  logic                     can_load;
  logic                     accept;
  logic                     pick_found;
  logic [P_GRANT_WIDTH-1:0] pick_idx;
  logic [P_GRANT_WIDTH-1:0] rr_ptr;
  logic [P_GRANT_WIDTH-1:0] sel;
  logic [P_GRANT_WIDTH-1:0] sel_nxt;
  logic                     sel_vld;
  logic                     sel_last;
  logic [P_DATA_WIDTH-1:0]  sel_data;

  cbb_rr_pick #(
    .P_NUM_SLV     (P_NUM_SLV),
    .P_GRANT_WIDTH (P_GRANT_WIDTH)
  ) u_pick (
    .req   (slv_i_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign can_load = ~mst_o_valid | mst_i_ready;

`ifdef CBB_RR_ARB_PKT_LOCK_EN
  arb_state_e               state;
  logic [P_GRANT_WIDTH-1:0] lock_idx;
  logic                     lock_vld;

  always_comb begin
    lock_vld = 1'b0;
    for (int k = 0; k < P_NUM_SLV; k++) begin
      if (lock_idx == P_GRANT_WIDTH'(k)) begin
        lock_vld = slv_i_valid[k];
      end
    end
  end

  // A locked requester that drops valid stalls the arbiter rather than yielding.
  assign sel     = (state == LOCK) ? lock_idx : pick_idx;
  assign sel_vld = (state == LOCK) ? lock_vld : pick_found;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      lock_idx <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!sel_last) begin
            state    <= LOCK;
            lock_idx <= sel;
          end
        end
        LOCK: begin
          if (sel_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign sel     = pick_idx;
  assign sel_vld = pick_found;
`endif

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < P_NUM_SLV; k++) begin
      if (sel == P_GRANT_WIDTH'(k)) begin
        sel_data = slv_i_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
        sel_last = slv_i_last[k];
      end
    end
  end

  assign accept = can_load & sel_vld;

  always_comb begin
    slv_o_ready = '0;
    for (int k = 0; k < P_NUM_SLV; k++) begin
      slv_o_ready[k] = accept & (sel == P_GRANT_WIDTH'(k));
    end
  end

  assign sel_nxt = (sel == P_GRANT_WIDTH'(P_NUM_SLV - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rr_ptr <= '0;
`ifdef CBB_RR_ARB_PKT_LOCK_EN
    end else if (accept && sel_last) begin
`else
    end else if (accept) begin
`endif
      rr_ptr <= sel_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mst_o_valid <= 1'b0;
      mst_o_last  <= 1'b0;
      mst_o_grant <= '0;
    end else if (can_load) begin
      mst_o_valid <= sel_vld;
      if (sel_vld) begin
        mst_o_last  <= sel_last;
        mst_o_grant <= sel;
      end
    end
  end

  // Payload is qualified by mst_o_valid, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mst_o_data <= sel_data;
    end
  end

endmodule

// File: tb/tb_cbb_rr_stream_arb.sv
// Bench for cbb_rr_stream_arb: directed scenarios plus random traffic, checked
// against a queue-based round-robin reference model; honours CBB_RR_ARB_PKT_LOCK_EN.
module tb_cbb_rr_stream_arb;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int GW = 2;
`ifdef CBB_RR_ARB_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef logic [W:0] beat_t;

  logic           i_clk;
  logic           i_rstn;
  logic [N-1:0]   slv_i_valid;
  logic [N*W-1:0] slv_i_data;
  logic [N-1:0]   slv_i_last;
  logic [N-1:0]   slv_o_ready;
  logic           mst_o_valid;
  logic [W-1:0]   mst_o_data;
  logic           mst_o_last;
  logic [GW-1:0]  mst_o_grant;
  logic           mst_i_ready;

  beat_t        src_q [N][$];
  logic [N-1:0] src_en;

  bit           m_vld, m_last, m_lock;
  logic [W-1:0] m_data;
  int           m_grant, m_ptr, m_lock_idx;

  int           n_checks;
  int           n_errors;
  logic [N-1:0] obs;

  int          s1_seq [5]    = '{0, 1, 2, 3, 0};
  int          s2_g_lock [4] = '{2, 2, 2, 1};
  int          s2_g_free [4] = '{2, 1, 2, 2};
  logic [63:0] s2_d_lock [4] = '{64'hA0, 64'hA1, 64'hA2, 64'hB0};
  logic [63:0] s2_d_free [4] = '{64'hA0, 64'hB0, 64'hA1, 64'hA2};
  int          s6_g_lock [4] = '{0, 0, 1, 1};
  int          s6_g_free [4] = '{0, 1, 0, 1};

  cbb_rr_stream_arb #(
    .P_DATA_WIDTH  (W),
    .P_NUM_SLV     (N),
    .P_GRANT_WIDTH (GW)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .slv_i_valid (slv_i_valid),
    .slv_i_data  (slv_i_data),
    .slv_i_last  (slv_i_last),
    .slv_o_ready (slv_o_ready),
    .mst_o_valid (mst_o_valid),
    .mst_o_data  (mst_o_data),
    .mst_o_last  (mst_o_last),
    .mst_o_grant (mst_o_grant),
    .mst_i_ready (mst_i_ready)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs_v, exp_v, $time);
    end
  endtask

  task automatic push(input int k, input logic [W-1:0] d, input logic l);
    src_q[k].push_back({l, d});
  endtask

  task automatic model_reset();
    m_vld = 0; m_last = 0; m_data = '0; m_grant = 0;
    m_ptr = 0; m_lock = 0; m_lock_idx = 0;
    for (int k = 0; k < N; k++) src_q[k].delete();
  endtask

  function automatic bit model_busy();
    bit busy;
    busy = m_vld;
    for (int k = 0; k < N; k++) if (src_q[k].size() > 0) busy = 1'b1;
    return busy;
  endfunction

  task automatic apply_reset();
    i_rstn      = 1'b0;
    slv_i_valid = '0;
    slv_i_last  = '0;
    slv_i_data  = '0;
    mst_i_ready = 1'b0;
    src_en      = '1;
    model_reset();
    repeat (2) @(negedge i_clk);
    check_val("rst_valid", mst_o_valid, 0);
    check_val("rst_last", mst_o_last, 0);
    check_val("rst_grant", mst_o_grant, 0);
    check_val("rst_ready", slv_o_ready, 0);
    i_rstn = 1'b1;
  endtask

  // One clock: drive sources from their queues, predict, compare, advance the model.
  task automatic do_cycle(input logic rdy, output logic [N-1:0] seen_rdy);
    logic [N-1:0] vin;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    int           who;
    bit           have;
    bit           can;
    for (int k = 0; k < N; k++) begin
      vin[k] = src_en[k] && (src_q[k].size() > 0);
      b = vin[k] ? src_q[k][0] : '0;
      slv_i_valid[k]         = vin[k];
      slv_i_last[k]          = b[W];
      slv_i_data[k*W +: W]   = b[W-1:0];
    end
    mst_i_ready = rdy;
    who  = 0;
    have = 0;
    if (m_lock) begin
      who  = m_lock_idx;
      have = vin[who];
    end else begin
      for (int j = 0; j < N; j++) begin
        if (!have && vin[(m_ptr + j) % N]) begin
          have = 1;
          who  = (m_ptr + j) % N;
        end
      end
    end
    can     = !m_vld || rdy;
    exp_rdy = (can && have) ? (N'(1) << who) : '0;
    #1;
    seen_rdy = slv_o_ready;
    check_val("ready", slv_o_ready, exp_rdy);
    check_val("o_valid", mst_o_valid, m_vld);
    check_val("o_last", mst_o_last, m_last);
    check_val("o_grant", mst_o_grant, m_grant);
    if (m_vld) check_val("o_data", mst_o_data, m_data);
    @(posedge i_clk);
    if (can) m_vld = have;
    if (can && have) begin
      b       = src_q[who].pop_front();
      m_data  = b[W-1:0];
      m_last  = b[W];
      m_grant = who;
      if (LOCK_EN) begin
        if (!m_lock && !b[W]) begin
          m_lock     = 1;
          m_lock_idx = who;
        end else if (m_lock && b[W]) begin
          m_lock = 0;
        end
        if (b[W]) m_ptr = (who + 1) % N;
      end else begin
        m_ptr = (who + 1) % N;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic drain();
    logic [N-1:0] d;
    int guard;
    guard  = 0;
    src_en = '1;
    while (model_busy() && guard < 200) begin
      do_cycle(1'b1, d);
      guard++;
    end
    check_val("drain_idle", mst_o_valid, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // All requesters valid, single-beat packets, ready held high.
    apply_reset();
    for (int k = 0; k < N; k++) begin
      push(k, 64'h10 + 64'(k), 1'b1);
      push(k, 64'h20 + 64'(k), 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, obs);
      check_val("s1_rdy", obs, N'(1) << s1_seq[i]);
      check_val("s1_vld", mst_o_valid, 1);
      check_val("s1_grant", mst_o_grant, s1_seq[i]);
    end
    drain();

    // Three-beat packet on requester 2 while requester 1 waits.
    apply_reset();
    push(1, 64'h11, 1'b1);
    do_cycle(1'b1, obs);
    push(2, 64'hA0, 1'b0);
    push(2, 64'hA1, 1'b0);
    push(2, 64'hA2, 1'b1);
    push(1, 64'hB0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, obs);
      check_val("s2_grant", mst_o_grant, LOCK_EN ? s2_g_lock[i] : s2_g_free[i]);
      check_val("s2_data", mst_o_data, LOCK_EN ? s2_d_lock[i] : s2_d_free[i]);
    end
    drain();

    // Downstream stall for five cycles.
    apply_reset();
    push(0, 64'hC0, 1'b0);
    push(0, 64'hC1, 1'b0);
    push(0, 64'hC2, 1'b0);
    push(0, 64'hC3, 1'b1);
    do_cycle(1'b1, obs);
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, obs);
      check_val("s3_stall_rdy", obs, 0);
      check_val("s3_stall_vld", mst_o_valid, 1);
      check_val("s3_stall_dat", mst_o_data, 64'hC0);
    end
    do_cycle(1'b1, obs);
    check_val("s3_resume_rdy", obs, 4'b0001);
    check_val("s3_resume_dat", mst_o_data, 64'hC1);
    drain();

    // Requester 0 drops valid mid-packet while requester 3 waits.
    apply_reset();
    push(0, 64'hD0, 1'b0);
    push(0, 64'hD1, 1'b0);
    push(0, 64'hD2, 1'b1);
    push(3, 64'hE0, 1'b1);
    do_cycle(1'b1, obs);
    src_en = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, obs);
      check_val("s4_rdy3", obs[3], (LOCK_EN || i > 0) ? 1'b0 : 1'b1);
      check_val("s4_out_vld", mst_o_valid, LOCK_EN ? 1'b0 : (i == 0));
    end
    drain();

    // Reset in the middle of a packet.
    apply_reset();
    push(1, 64'hF0, 1'b0);
    push(1, 64'hF1, 1'b0);
    push(1, 64'hF2, 1'b1);
    do_cycle(1'b1, obs);
    #2 i_rstn = 1'b0;
    #1;
    check_val("s5_async_vld", mst_o_valid, 0);
    check_val("s5_async_grant", mst_o_grant, 0);
    model_reset();
    slv_i_valid = '0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    push(0, 64'h70, 1'b1);
    push(2, 64'h72, 1'b1);
    do_cycle(1'b1, obs);
    check_val("s5_restart_rdy", obs, 4'b0001);
    drain();
    push(3, 64'h73, 1'b1);
    do_cycle(1'b1, obs);
    check_val("s5_rdy3", obs, 4'b1000);
    check_val("s5_grant3", mst_o_grant, 3);
    drain();

    // Two 2-beat packets from requesters 0 and 1.
    apply_reset();
    push(0, 64'h60, 1'b0);
    push(0, 64'h61, 1'b1);
    push(1, 64'h68, 1'b0);
    push(1, 64'h69, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, obs);
      check_val("s6_grant", mst_o_grant, LOCK_EN ? s6_g_lock[i] : s6_g_free[i]);
    end
    drain();

    // Random packets, valid gaps and downstream backpressure.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() < 3 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push(k, {$urandom, $urandom}, b == len - 1);
        end
        src_en[k] = ($urandom_range(0, 4) != 0);
      end
      do_cycle($urandom_range(0, 3) != 0, obs);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
